// File: rtl/meta_ctrl_pkg.sv
// Shared sizing, FSM state type and the way-mask expansion helper for the
// metadata array controller.
package meta_ctrl_pkg;
  localparam int SETS       = 512;
  localparam int WAYS       = 4;
  localparam int DATA_W     = 2;
  localparam int SET_W      = $clog2(SETS);
  localparam int STARVE_MAX = 4;
  localparam int ROW_W      = WAYS * DATA_W;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Widen a per-way enable into a per-bit enable across the whole row.
  function automatic logic [ROW_W-1:0] way_bits(input logic [WAYS-1:0] mask);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < WAYS; i++) begin
      r[i*DATA_W +: DATA_W] = {DATA_W{mask[i]}};
    end
    return r;
  endfunction
endpackage

// File: rtl/meta_array_ctrl_if.sv
// Request-side bus (read + two write ports) and the array-side port bundle.
interface meta_array_ctrl_if;
  import meta_ctrl_pkg::*;
  logic             rd_valid;
  logic             rd_ready;
  logic [SET_W-1:0] rd_set;
  logic             rd_resp_valid;
  logic [ROW_W-1:0] rd_resp_data;
  logic             w0_valid, w0_ready;
  logic [SET_W-1:0] w0_set;
  logic [WAYS-1:0]  w0_mask;
  logic [ROW_W-1:0] w0_data;
  logic             w1_valid, w1_ready;
  logic [SET_W-1:0] w1_set;
  logic [WAYS-1:0]  w1_mask;
  logic [ROW_W-1:0] w1_data;

  modport master (
    output rd_valid, rd_set, w0_valid, w0_set, w0_mask, w0_data,
           w1_valid, w1_set, w1_mask, w1_data,
    input  rd_ready, rd_resp_valid, rd_resp_data, w0_ready, w1_ready
  );
  modport slave (
    input  rd_valid, rd_set, w0_valid, w0_set, w0_mask, w0_data,
           w1_valid, w1_set, w1_mask, w1_data,
    output rd_ready, rd_resp_valid, rd_resp_data, w0_ready, w1_ready
  );
endinterface

interface meta_arr_if;
  import meta_ctrl_pkg::*;
  logic [SET_W-1:0] r_addr;
  logic [ROW_W-1:0] r_data;
  logic             w_en;
  logic [SET_W-1:0] w_addr;
  logic [ROW_W-1:0] w_data;
  logic [WAYS-1:0]  w_mask;

  modport master (output r_addr, w_en, w_addr, w_data, w_mask, input r_data);
  modport slave  (input r_addr, w_en, w_addr, w_data, w_mask, output r_data);
endinterface

// File: rtl/meta_wr_arb.sv
// Two-port write arbiter: w0 has priority, w1 wins once it has lost
// STARVE_MAX consecutive cycles while still requesting.
module meta_wr_arb #(
  parameter int STARVE_MAX = meta_ctrl_pkg::STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic w0_valid_i,
  input  logic w1_valid_i,
  output logic gnt0_o,
  output logic gnt1_o
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_MAX));
  assign gnt1_o  = en_i && w1_valid_i && (!w0_valid_i || starved);
  assign gnt0_o  = en_i && w0_valid_i && !gnt1_o;

  always_comb begin
    starve_d = starve_q;
    if (!w1_valid_i || gnt1_o) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
endmodule

// File: rtl/meta_array_ctrl.sv
// Metadata array controller: clears the array after reset/flush, then serves
// one read and one arbitrated write per cycle with same-set write bypass.
//   state | meaning
//   WAIT  | post-reset idle cycle, everything quiet
//   INIT  | zero one set per cycle, init_cnt 0..SETS-1
//   RUN   | requests accepted, init_done high
module meta_array_ctrl
  import meta_ctrl_pkg::*;
#(
  parameter int SETS       = meta_ctrl_pkg::SETS,
  parameter int WAYS       = meta_ctrl_pkg::WAYS,
  parameter int DATA_W     = meta_ctrl_pkg::DATA_W,
  parameter int STARVE_MAX = meta_ctrl_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_req_i,
  output logic              init_done_o,
  meta_array_ctrl_if.slave  req,
  meta_arr_if.master        arr
);
  localparam int CNT_W = $clog2(SETS);
  localparam int ROW_B = WAYS * DATA_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic             rsp_vld_q;
  logic [WAYS-1:0]  byp_mask_q, byp_mask_d;
  logic [ROW_B-1:0] byp_data_q, byp_data_d;
  logic             run, rd_acc, gnt0, gnt1;
  logic [ROW_B-1:0] byp_bits;

  assign run         = (state_q == RUN);
  assign init_done_o = run;
  assign rd_acc      = req.rd_valid && run;
  assign req.rd_ready = run;
  assign req.w0_ready = gnt0;
  assign req.w1_ready = gnt1;
  assign arr.r_addr  = req.rd_set;

  meta_wr_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (run),
    .w0_valid_i (req.w0_valid),
    .w1_valid_i (req.w1_valid),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    arr.w_en   = 1'b0;
    arr.w_addr = '0;
    arr.w_data = '0;
    arr.w_mask = '0;
    case (state_q)
      WAIT: state_d = INIT;
      INIT: begin
        arr.w_en   = 1'b1;
        arr.w_addr = init_cnt_q;
        arr.w_mask = '1;
        if (init_cnt_q == CNT_W'(SETS - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (gnt1) begin
          arr.w_en   = 1'b1;
          arr.w_addr = req.w1_set;
          arr.w_data = req.w1_data;
          arr.w_mask = req.w1_mask;
        end else if (gnt0) begin
          arr.w_en   = 1'b1;
          arr.w_addr = req.w0_set;
          arr.w_data = req.w0_data;
          arr.w_mask = req.w0_mask;
        end
        if (flush_req_i) begin
          state_d    = INIT;
          init_cnt_d = '0;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  // The array still returns the pre-write row next cycle, so a same-set write
  // is captured here and merged over it when the response comes back.
  always_comb begin
    byp_mask_d = '0;
    byp_data_d = arr.w_data;
    if (rd_acc && (gnt0 || gnt1) && (arr.w_addr == req.rd_set)) begin
      byp_mask_d = arr.w_mask;
    end
  end

  assign byp_bits = way_bits(byp_mask_q);
  assign req.rd_resp_valid = rsp_vld_q;
  assign req.rd_resp_data  = rsp_vld_q ? ((arr.r_data & ~byp_bits) | (byp_data_q & byp_bits))
                                       : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT;
      init_cnt_q <= '0;
      rsp_vld_q  <= 1'b0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rsp_vld_q  <= rd_acc;
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
    end
  end
endmodule

// File: tb/tb_meta_array_ctrl.sv
// Directed bench for meta_array_ctrl with a behavioural one-cycle-latency array.
module tb_meta_array_ctrl;
  import meta_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0;
  logic init_done;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;

  logic [7:0] mem [512];

  always #5 clk = ~clk;

  meta_array_ctrl_if req_if ();
  meta_arr_if        arr_if ();

  meta_array_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_req_i (flush_req),
    .init_done_o (init_done),
    .req         (req_if.slave),
    .arr         (arr_if.master)
  );

  function automatic logic [7:0] expand(input logic [3:0] m);
    return {{2{m[3]}}, {2{m[2]}}, {2{m[1]}}, {2{m[0]}}};
  endfunction

  always @(posedge clk) begin
    if (arr_if.w_en)
      mem[arr_if.w_addr] <= (mem[arr_if.w_addr] & ~expand(arr_if.w_mask)) |
                            (arr_if.w_data & expand(arr_if.w_mask));
    arr_if.r_data <= mem[arr_if.r_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    req_if.rd_valid = 1'b0; req_if.rd_set = '0;
    req_if.w0_valid = 1'b0; req_if.w0_set = '0; req_if.w0_mask = '0; req_if.w0_data = '0;
    req_if.w1_valid = 1'b0; req_if.w1_set = '0; req_if.w1_mask = '0; req_if.w1_data = '0;
  endtask

  task automatic wait_init_done(input string tag);
    n = 0;
    while (!init_done && n < 600) begin
      @(negedge clk); #1; n++;
    end
    chk(tag, 32'(init_done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h5A;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_if.rd_valid = 1'b1; req_if.w0_valid = 1'b1; req_if.w1_valid = 1'b1;
    #1;
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_readies", {29'd0, req_if.rd_ready, req_if.w0_ready, req_if.w1_ready}, 0);
    chk("rst_w_en", 32'(arr_if.w_en), 0);
    chk("rst_resp", {23'd0, req_if.rd_resp_valid, req_if.rd_resp_data}, 0);
    idle();
    @(negedge clk) rst_n = 1'b1;

    // Clear sweep: set k-1 visible after the k-th edge, RUN after edge 513.
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      if (k == 1) req_if.rd_valid = 1'b1;
      #1;
      chk("init_wr", {arr_if.w_en, arr_if.w_mask, arr_if.w_data, 10'(arr_if.w_addr)},
          {1'b1, 4'hF, 8'h00, 10'(k - 1)});
      if (k == 1) begin
        chk("init_ready", {29'd0, req_if.rd_ready, req_if.w0_ready, req_if.w1_ready}, 0);
        idle();
      end
      if (k == 512) chk("init_done_512", 32'(init_done), 0);
    end
    @(negedge clk); #1;
    chk("init_done_513", 32'(init_done), 1);
    chk("run_rd_ready", 32'(req_if.rd_ready), 1);

    // Both writers valid: w1 wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_if.w0_valid = 1'b1; req_if.w0_set = 9'd20; req_if.w0_mask = 4'hF; req_if.w0_data = 8'h11;
        req_if.w1_valid = 1'b1; req_if.w1_set = 9'd21; req_if.w1_mask = 4'hF; req_if.w1_data = 8'h22;
      end
      #1;
      chk("arb_gnt", {30'd0, req_if.w0_ready, req_if.w1_ready}, (i % 5 == 4) ? 32'd1 : 32'd2);
      chk("arb_addr", 32'(arr_if.w_addr), (i % 5 == 4) ? 32'd21 : 32'd20);
    end
    @(negedge clk); req_if.w0_valid = 1'b0; #1;
    chk("arb_w1_alone", {30'd0, req_if.w0_ready, req_if.w1_ready}, 32'd1);
    @(negedge clk); req_if.w0_valid = 1'b1; req_if.w1_valid = 1'b0; #1;
    chk("arb_w0_alone", {30'd0, req_if.w0_ready, req_if.w1_ready}, 32'd2);

    // Same-set bypass: way 1 takes write data, others from the cleared array.
    @(negedge clk); idle();
    req_if.w0_valid = 1'b1; req_if.w0_set = 9'd5; req_if.w0_mask = 4'b0010; req_if.w0_data = 8'hFF;
    req_if.rd_valid = 1'b1; req_if.rd_set = 9'd5;
    #1;
    chk("byp_accept", {30'd0, req_if.rd_ready, req_if.w0_ready}, 32'd3);
    @(negedge clk); idle(); #1;
    chk("byp_resp", {23'd0, req_if.rd_resp_valid, req_if.rd_resp_data}, {23'd0, 1'b1, 8'h0C});
    @(negedge clk); req_if.rd_valid = 1'b1; req_if.rd_set = 9'd5; #1;
    chk("resp_single", 32'(req_if.rd_resp_valid), 0);
    // A write landing in the response cycle must not leak into it.
    @(negedge clk); idle();
    req_if.w0_valid = 1'b1; req_if.w0_set = 9'd5; req_if.w0_mask = 4'hF; req_if.w0_data = 8'hAA;
    #1;
    chk("late_wr_resp", 32'(req_if.rd_resp_data), 32'h0C);
    @(negedge clk); idle();
    req_if.rd_valid = 1'b1; req_if.rd_set = 9'd5;
    req_if.w0_valid = 1'b1; req_if.w0_set = 9'd5; req_if.w0_mask = 4'b0001; req_if.w0_data = 8'h03;
    #1;
    @(negedge clk); idle(); #1;
    chk("byp_merge", 32'(req_if.rd_resp_data), 32'hAB);
    @(negedge clk);
    req_if.rd_valid = 1'b1; req_if.rd_set = 9'd7;
    req_if.w1_valid = 1'b1; req_if.w1_set = 9'd5; req_if.w1_mask = 4'hF; req_if.w1_data = 8'h55;
    #1;
    @(negedge clk); idle(); #1;
    chk("no_byp_other_set", {23'd0, req_if.rd_resp_valid, req_if.rd_resp_data}, {23'd0, 1'b1, 8'h00});

    // Flush with a read in flight.
    @(negedge clk); req_if.rd_valid = 1'b1; req_if.rd_set = 9'd5; flush_req = 1'b1; #1;
    chk("flush_rd_ready", {30'd0, req_if.rd_ready, init_done}, 32'd3);
    @(negedge clk); idle(); flush_req = 1'b0; #1;
    chk("flush_resp", {23'd0, req_if.rd_resp_valid, req_if.rd_resp_data}, {23'd0, 1'b1, 8'h55});
    chk("flush_init_done", 32'(init_done), 0);
    chk("flush_first_wr", {arr_if.w_en, 10'(arr_if.w_addr)}, {1'b1, 10'd0});
    n = 0;
    while (!init_done && n < 600) begin
      @(negedge clk); flush_req = (n == 10); #1; n++;
    end
    flush_req = 1'b0;
    chk("flush_len", 32'(n), 32'd512);
    @(negedge clk); req_if.rd_valid = 1'b1; req_if.rd_set = 9'd5; #1;
    @(negedge clk); idle(); #1;
    chk("flush_cleared", {23'd0, req_if.rd_resp_valid, req_if.rd_resp_data}, {23'd0, 1'b1, 8'h00});

    // Reset landing mid-clear.
    @(negedge clk); flush_req = 1'b1; #1;
    @(negedge clk); flush_req = 1'b0; #1;
    n = 0;
    while (arr_if.w_addr != 9'd100 && n < 600) begin
      @(negedge clk); #1; n++;
    end
    chk("mid_init_addr", 32'(arr_if.w_addr), 32'd100);
    req_if.rd_valid = 1'b1; req_if.rd_set = 9'd5; req_if.w0_valid = 1'b1; req_if.w1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_w_en", 32'(arr_if.w_en), 0);
    chk("mid_rst_readies", {29'd0, req_if.rd_ready, req_if.w0_ready, req_if.w1_ready}, 0);
    chk("mid_rst_outs", {22'd0, init_done, req_if.rd_resp_valid, req_if.rd_resp_data}, 0);
    @(negedge clk); idle(); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("restart_set0", {arr_if.w_en, arr_if.w_mask, 10'(arr_if.w_addr)}, {1'b1, 4'hF, 10'd0});
    wait_init_done("restart_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/meta_array_ctrl.md
META_ARRAY_CTRL -- requirements
Module: meta_array_ctrl

Interface
REQ-001 Parameters SHALL be: SETS, default 512, number of array sets; WAYS, default 4, number of ways; DATA_W, default 2, bits per way; STARVE_MAX, default 4, consecutive losses before the low-priority writer wins.
REQ-002 clock  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  asynchronous reset, active-low.
REQ-004 flush_req  in  1  single-cycle pulse; re-clears the whole array.
REQ-005 init_done  out  1  high when the array is cleared and requests are accepted.
REQ-006 rd_valid / rd_ready / rd_set  in / out / in  1 / 1 / log2(SETS)  read request handshake.
REQ-007 rd_resp_valid / rd_resp_data  out / out  1 / WAYS*DATA_W  read response; way i occupies bits [i*DATA_W +: DATA_W].
REQ-008 w0_valid / w0_ready / w0_set / w0_mask / w0_data  in / out / in / in / in  1 / 1 / log2(SETS) / WAYS / WAYS*DATA_W  high-priority write port (refill).
REQ-009 w1_valid / w1_ready / w1_set / w1_mask / w1_data  same widths as w0  low-priority write port (state update).
REQ-010 arr_r_addr / arr_r_data  out / in  log2(SETS) / WAYS*DATA_W  array read port; the array returns data one cycle after the address.
REQ-011 arr_w_en / arr_w_addr / arr_w_data / arr_w_mask  out  1 / log2(SETS) / WAYS*DATA_W / WAYS  array write port; arr_w_mask is a per-way enable.

Function
REQ-012 The FSM SHALL have three states: WAIT (the reset state), INIT and RUN.
REQ-013 WAIT SHALL drive all readies, arr_w_en and init_done low, and SHALL go to INIT on the next edge.
REQ-014 INIT SHALL write zero to all ways (arr_w_mask all ones) of set init_cnt each cycle, with init_cnt running from 0 to SETS-1.
REQ-015 After set SETS-1 is written, INIT SHALL go to RUN, and init_done SHALL rise in the first RUN cycle, giving SETS+1 cycles from reset release.
REQ-016 In INIT, rd_ready, w0_ready and w1_ready SHALL be low and rd_resp_valid SHALL stay low.
REQ-017 In RUN, rd_ready SHALL be high; a read is accepted when rd_valid && rd_ready, and arr_r_addr = rd_set in that cycle.
REQ-018 rd_resp_valid SHALL be high exactly one cycle after an accepted read, with no backpressure.
REQ-019 In RUN, the arbiter SHALL grant w0 whenever w0_valid is high, except when the starvation counter has reached STARVE_MAX and w1_valid is high, in which case w1 is granted.
REQ-020 The starvation counter SHALL increment on each cycle w1_valid is high and w1 is not granted, clear on a w1 grant or when w1_valid is low, and saturate at STARVE_MAX.
REQ-021 Ready SHALL be combinational, and only the granted port's ready is high; a grant drives arr_w_en=1 with that port's set, data and mask in the same cycle.
REQ-022 A read and a write SHALL both be accepted in the same cycle.
REQ-023 If the granted write set equals the accepted read set in that cycle, the response SHALL return the written data for ways in the write mask and the array data for the other ways; this is a registered bypass.
REQ-024 A write accepted in the response cycle SHALL NOT alter that response.
REQ-025 flush_req in RUN SHALL move the FSM to INIT with init_cnt=0 on the next edge.
REQ-026 When flush_req arrives in RUN, requests in that same cycle are still accepted and the pending response is still delivered; init_done falls on the next edge.
REQ-027 flush_req in WAIT or INIT SHALL be ignored.

Reset
REQ-028 Asserting reset SHALL immediately force: state=WAIT, init_cnt=0, starvation counter=0, bypass registers=0, rd_resp_valid=0, init_done=0.
REQ-029 Under reset all readies and arr_w_en SHALL be 0 and rd_resp_data SHALL be 0, including when reset is asserted mid-INIT or mid-transaction.

Structure
REQ-030 Package meta_ctrl_pkg SHALL hold SETS, WAYS, DATA_W, SET_W=log2(SETS), STARVE_MAX and the state enum {WAIT, INIT, RUN}.
REQ-031 The write arbiter with its starvation counter SHALL be a sub-module, meta_wr_arb; all other logic lives in meta_array_ctrl.

Verification
REQ-032 Release reset: arr_w_en=1 with mask 4'hF and data 0 for sets 0..511 in order, and init_done=1 exactly 513 cycles after release.
REQ-033 In RUN, w0 and w1 both valid continuously: w0 granted 4 cycles, w1 granted on the 5th, and the pattern repeats.
REQ-034 Write set 5, mask 4'b0010, data 8'hFF, plus read set 5 in the same cycle with the array holding 8'h00: next-cycle rd_resp_data = 8'h0C.
REQ-035 flush_req while a read is accepted: the response is delivered next cycle, init_done=0, then the 512-set clear repeats and init_done returns.
REQ-036 Assert reset at INIT set 100: all outputs 0 immediately, and after release the clear restarts at set 0.
